// File: rtl/i2s_transmitter_if.sv
// Sample and serial-link signals between an audio source and the I2S transmitter.
// The source drives samples and mute; the transmitter drives the codec-facing pins.
interface i2s_transmitter_if #(
  parameter int BITSIZE = 24
);
  logic signed [BITSIZE-1:0] left_in;
  logic signed [BITSIZE-1:0] right_in;
  logic                      mute;
  logic                      lrclk;
  logic                      sdata;
  logic                      sample_strobe;

  modport master (
    output left_in, right_in, mute,
    input  lrclk, sdata, sample_strobe
  );

  modport slave (
    input  left_in, right_in, mute,
    output lrclk, sdata, sample_strobe
  );
endinterface

// File: rtl/i2s_transmitter.sv
// I2S serialiser: frame counter, word-clock generation, and coherent stereo sample latch.
// Every register updates on the falling edge of bclk so that the codec samples on rising edges.
module i2s_transmitter #(
  parameter int BITSIZE  = 24,
  parameter int SLOTBITS = 32
) (
  input logic          bclk,
  input logic          reset,
  i2s_transmitter_if.slave bus
);
  localparam int FRAMEBITS = 2 * SLOTBITS;
  localparam int CW        = $clog2(FRAMEBITS);
  localparam logic [CW-1:0] LAST_SLOT = CW'(FRAMEBITS - 1);
  localparam logic [CW-1:0] SLOT_C    = CW'(SLOTBITS);
  localparam logic [CW-1:0] BITS_C    = CW'(BITSIZE);

  logic [CW-1:0]      bitcnt_q, bitcnt_d;
  logic [CW-1:0]      slot_j;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic               strobe_q, strobe_d;
  logic [BITSIZE-1:0] shift_q, shift_d;
  logic [BITSIZE-1:0] hold_right_q, hold_right_d;

  // Outputs are computed from the slot being entered, so each pin is a plain flop.
  always_comb begin
    bitcnt_d     = (bitcnt_q == LAST_SLOT) ? '0 : bitcnt_q + 1'b1;
    slot_j       = (bitcnt_d >= SLOT_C) ? bitcnt_d - SLOT_C : bitcnt_d;
    lrclk_d      = (bitcnt_d >= SLOT_C);
    strobe_d     = (bitcnt_q == LAST_SLOT);
    sdata_d      = 1'b0;
    shift_d      = shift_q;
    hold_right_d = hold_right_q;
    if (bitcnt_q == LAST_SLOT) begin
      // Left goes straight into the shifter; right waits so both come from one instant.
      shift_d      = bus.mute ? '0 : bus.left_in;
      hold_right_d = bus.mute ? '0 : bus.right_in;
    end else if (bitcnt_d == SLOT_C) begin
      shift_d = hold_right_q;
    end else if (slot_j <= BITS_C) begin
      sdata_d = shift_q[BITSIZE-1];
      shift_d = {shift_q[BITSIZE-2:0], 1'b0};
    end
  end

  always_ff @(negedge bclk or posedge reset) begin
    if (reset) begin
      bitcnt_q     <= '0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      strobe_q     <= 1'b0;
      shift_q      <= '0;
      hold_right_q <= '0;
    end else begin
      bitcnt_q     <= bitcnt_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      strobe_q     <= strobe_d;
      shift_q      <= shift_d;
      hold_right_q <= hold_right_d;
    end
  end

  assign bus.lrclk         = lrclk_q;
  assign bus.sdata         = sdata_q;
  assign bus.sample_strobe = strobe_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: captures whole frames and compares them with
// frames built arithmetically from the I2S slot rules, for 24-bit and 16-bit instances.
module tb_i2s_transmitter;
  logic bclk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   m_slot = 0;

  i2s_transmitter_if #(.BITSIZE(24)) bus ();
  i2s_transmitter_if #(.BITSIZE(16)) bus16 ();

  i2s_transmitter #(.BITSIZE(24), .SLOTBITS(32)) dut (
    .bclk (bclk), .reset (reset), .bus (bus)
  );
  i2s_transmitter #(.BITSIZE(16), .SLOTBITS(32)) dut16 (
    .bclk (bclk), .reset (reset), .bus (bus16)
  );

  always #5 bclk = ~bclk;

  // Slot position as the bench understands it: counts falling edges since reset.
  always @(negedge bclk or posedge reset) begin
    if (reset) m_slot <= 0;
    else       m_slot <= (m_slot + 1) % 64;
  end

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        m;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;

  localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

  function automatic logic [63:0] ref_frame(input int b, input logic [23:0] l, input logic [23:0] r);
    logic [63:0] e;
    logic [23:0] w;
    int j;
    e = '0;
    for (int k = 0; k < 64; k++) begin
      j = k % 32;
      w = (k < 32) ? l : r;
      if (j >= 1 && j <= b) e[k] = w[b-j];
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at the rising edge inside slot 0; returns at the rising edge of the next slot 0.
  task automatic capture(input int chg_slot, input logic [23:0] chg_left,
                         output logic [63:0] d, output logic [63:0] lr,
                         output logic [63:0] st, output logic [63:0] d16);
    chk("frame_align", 64'(m_slot), 64'd0);
    for (int k = 0; k < 64; k++) begin
      if (k == chg_slot) bus.left_in = chg_left;
      d[k]   = bus.sdata;
      lr[k]  = bus.lrclk;
      st[k]  = bus.sample_strobe;
      d16[k] = bus16.sdata;
      @(posedge bclk);
    end
  endtask

  vec_t        tbl[5];
  logic [63:0] d, lr, st, d16;
  logic [23:0] pl, pr, nl, nr;
  logic        nm;
  logic [63:0] e16;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{24'h800001, 24'h7FFFFE, 1'b0, 24'h800001, 24'h7FFFFE};
    tbl[1] = '{24'h000000, 24'hFFFFFF, 1'b0, 24'h000000, 24'hFFFFFF};
    tbl[2] = '{24'h5A5A5A, 24'hA5A5A5, 1'b1, 24'h000000, 24'h000000};
    tbl[3] = '{24'h13579B, 24'h2468AC, 1'b0, 24'h13579B, 24'h2468AC};
    tbl[4] = '{24'hFFFFFF, 24'h800000, 1'b0, 24'hFFFFFF, 24'h800000};
    e16 = ref_frame(16, 24'h00A5A5, 24'h003C3C);

    bus.left_in = '0; bus.right_in = '0; bus.mute = 1'b0;
    bus16.left_in = 16'hA5A5; bus16.right_in = 16'h3C3C; bus16.mute = 1'b0;

    #23;
    chk("rst_lrclk", 64'(bus.lrclk), 64'd0);
    chk("rst_sdata", 64'(bus.sdata), 64'd0);
    chk("rst_strobe", 64'(bus.sample_strobe), 64'd0);
    @(posedge bclk);
    reset = 1'b0;

    // Table: inputs applied in frame i are transmitted in frame i+1.
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        bus.left_in = tbl[i].l; bus.right_in = tbl[i].r; bus.mute = tbl[i].m;
      end
      capture(-1, 24'h0, d, lr, st, d16);
      if (i == 0) begin
        chk("tbl_data_first", d, 64'd0);
        chk("tbl_strobe_first", st, 64'd0);
        chk("b16_first", d16, 64'd0);
      end else begin
        chk($sformatf("tbl_data_%0d", i - 1), d, ref_frame(24, tbl[i-1].el, tbl[i-1].er));
        chk("tbl_strobe", st, 64'd1);
        chk("b16_data", d16, e16);
      end
      chk("tbl_lrclk", lr, LR_EXP);
    end
    bus.mute = 1'b0;

    // Randomised frames against the arithmetic frame model.
    pl = tbl[4].el; pr = tbl[4].er;
    for (int i = 0; i < 8; i++) begin
      nl = 24'($urandom); nr = 24'($urandom); nm = ($urandom_range(0, 3) == 0);
      bus.left_in = nl; bus.right_in = nr; bus.mute = nm;
      capture(-1, 24'h0, d, lr, st, d16);
      chk("rand_data", d, ref_frame(24, pl, pr));
      chk("rand_strobe", st, 64'd1);
      pl = nm ? 24'h0 : nl;
      pr = nm ? 24'h0 : nr;
    end
    bus.mute = 1'b0;

    // Left input changes mid-frame: only the following frame picks it up.
    bus.left_in = 24'h123456; bus.right_in = 24'h0F0F0F;
    capture(-1, 24'h0, d, lr, st, d16);
    chk("pre_mid_data", d, ref_frame(24, pl, pr));
    capture(10, 24'hABCDEF, d, lr, st, d16);
    chk("mid_frame_keep", d, ref_frame(24, 24'h123456, 24'h0F0F0F));
    capture(-1, 24'h0, d, lr, st, d16);
    chk("mid_frame_next", d, ref_frame(24, 24'hABCDEF, 24'h0F0F0F));

    // Reset at slot 40 of an all-ones frame.
    bus.left_in = 24'hFFFFFF; bus.right_in = 24'hFFFFFF;
    capture(-1, 24'h0, d, lr, st, d16);
    for (int n = 0; n < 64 && m_slot != 40; n++) @(posedge bclk);
    chk("rst_reach_slot40", 64'(m_slot), 64'd40);
    chk("pre_rst_sdata", 64'(bus.sdata), 64'd1);
    chk("pre_rst_lrclk", 64'(bus.lrclk), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_lrclk", 64'(bus.lrclk), 64'd0);
    chk("async_rst_sdata", 64'(bus.sdata), 64'd0);
    chk("async_rst_strobe", 64'(bus.sample_strobe), 64'd0);
    @(posedge bclk);
    @(posedge bclk);
    reset = 1'b0;
    capture(-1, 24'h0, d, lr, st, d16);
    chk("post_rst_data", d, 64'd0);
    chk("post_rst_strobe", st, 64'd0);
    chk("post_rst_lrclk", lr, LR_EXP);
    chk("post_rst_b16", d16, 64'd0);
    capture(-1, 24'h0, d, lr, st, d16);
    chk("post_rst_data2", d, ref_frame(24, 24'hFFFFFF, 24'hFFFFFF));
    chk("post_rst_strobe2", st, 64'd1);
    chk("post_rst_b16_2", d16, e16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
